// File: rtl/fifo_wr_skid.sv
// Stream-to-FIFO write front end with a two-entry skid buffer in the write clock domain.
// Latency: a word accepted on edge n is presented with WR_EN=1 in cycle n+1 when WR_FULL=0.
// Backpressure: IN_READY is registered; WR_FULL only stalls the head, E1 absorbs the in-flight word.
module fifo_wr_skid #(
  parameter int DATA_WIDTH = 360,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  WR_CLK,
  input  logic                  WR_RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_EN,
  input  logic                  WR_FULL,
  output logic [1:0]            BUF_CNT,
  output logic [CNT_WIDTH-1:0]  BEAT_CNT
);

  logic [DATA_WIDTH-1:0] r_e0;
  logic [DATA_WIDTH-1:0] r_e1;
  logic [1:0]            r_cnt;
  logic                  r_rdy;
  logic [CNT_WIDTH-1:0]  r_beat;

  logic                  w_accept;
  logic                  w_push;
  logic [1:0]            w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_e0_nxt;
  logic [DATA_WIDTH-1:0] w_e1_nxt;

  // Handshakes: the write is gated by reset too so nothing leaves during the reset cycle.
  assign w_accept = IN_VALID & r_rdy & ~FLUSH;
  assign w_push   = (r_cnt != 2'd0) & ~WR_FULL & ~FLUSH & ~WR_RST;

  assign WR_EN    = w_push;
  assign WR_DATA  = r_e0;
  assign IN_READY = r_rdy;
  assign BUF_CNT  = r_cnt;
  assign BEAT_CNT = r_beat;

  // Next buffer occupancy and entry contents; E0 always holds the oldest word.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    if (FLUSH) begin
      w_cnt_nxt = 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_accept) begin
            w_e0_nxt  = IN_DATA;
            w_cnt_nxt = 2'd1;
          end
        end
        2'd1: begin
          if (w_accept && w_push) begin
            w_e0_nxt = IN_DATA;
          end else if (w_accept) begin
            w_e1_nxt  = IN_DATA;
            w_cnt_nxt = 2'd2;
          end else if (w_push) begin
            w_cnt_nxt = 2'd0;
          end
        end
        2'd2: begin
          // IN_READY is low here, so only the head can move.
          if (w_push) begin
            w_e0_nxt  = r_e1;
            w_cnt_nxt = 2'd1;
          end
        end
        default: begin
          w_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  // State registers; IN_READY looks ahead at the next occupancy so it needs no path from WR_FULL.
  always_ff @(posedge WR_CLK) begin
    if (WR_RST) begin
      r_e0   <= '0;
      r_e1   <= '0;
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b0;
      r_beat <= '0;
    end else begin
      r_e0  <= w_e0_nxt;
      r_e1  <= w_e1_nxt;
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (w_push) begin
        r_beat <= r_beat + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_skid.sv
// Bench for fifo_wr_skid: queue-based reference model checked every cycle plus directed checks.
// Latency: model tracks one-cycle accept-to-write timing and registered IN_READY.
// Backpressure: WR_FULL and FLUSH are driven directly; IN_VALID is directed or random.
module tb_fifo_wr_skid;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_dat;
  logic          in_vld;
  logic          in_rdy;
  logic          flush;
  logic [DW-1:0] wr_dat;
  logic          wr_en;
  logic          wr_full;
  logic [1:0]    buf_cnt;
  logic [CW-1:0] beat_cnt;

  fifo_wr_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .WR_CLK   (clk),
    .WR_RST   (rst),
    .IN_DATA  (in_dat),
    .IN_VALID (in_vld),
    .IN_READY (in_rdy),
    .FLUSH    (flush),
    .WR_DATA  (wr_dat),
    .WR_EN    (wr_en),
    .WR_FULL  (wr_full),
    .BUF_CNT  (buf_cnt),
    .BEAT_CNT (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] sb_q[$];
  logic          m_rdy;
  int            m_beat;
  logic [DW-1:0] next_data;
  int            n_acc;
  bit            mon_en;

  // Per-cycle scoreboard: compare DUT outputs to the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_en;
      logic acc;
      exp_en = (sb_q.size() != 0) && !wr_full && !flush && !rst;
      acc    = in_vld && m_rdy && !flush;
      check_eq("in_ready", {63'd0, in_rdy}, {63'd0, m_rdy});
      check_eq("buf_cnt", {62'd0, buf_cnt}, 64'(sb_q.size()));
      check_eq("wr_en", {63'd0, wr_en}, {63'd0, exp_en});
      check_eq("beat_cnt", {60'd0, beat_cnt}, 64'(m_beat % 16));
      if (buf_cnt > 2'd2) check_eq("buf_cnt_max", {62'd0, buf_cnt}, 64'd2);
      if (exp_en && wr_en) check_eq("wr_data", {48'd0, wr_dat}, {48'd0, sb_q[0]});
      if (rst) begin
        sb_q.delete();
        m_rdy  = 1'b0;
        m_beat = 0;
      end else if (flush) begin
        sb_q.delete();
        m_rdy = 1'b1;
      end else begin
        if (exp_en) begin
          void'(sb_q.pop_front());
          m_beat++;
        end
        if (acc) begin
          sb_q.push_back(in_dat);
          next_data = next_data + 1'b1;
          n_acc++;
        end
        m_rdy = (sb_q.size() < 2);
      end
    end
  end

  task automatic cyc(input logic v, input logic f, input logic fl, input logic r);
    in_vld  = v;
    in_dat  = next_data;
    wr_full = f;
    flush   = fl;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int start;
    int budget;
    int beat_save;
    n_cmp = 0; n_bad = 0;
    m_rdy = 1'b0; m_beat = 0; n_acc = 0; mon_en = 0;
    next_data = 16'h1;
    in_vld = 0; in_dat = '0; wr_full = 0; flush = 0; rst = 1;
    @(posedge clk);
    #1;
    mon_en = 1;
    check_eq("rst_wr_data", {48'd0, wr_dat}, 64'd0);
    check_eq("rst_wr_en", {63'd0, wr_en}, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rdy_after_rst", {63'd0, in_rdy}, 64'd1);

    // Stream 1..8 with no backpressure
    budget = 0;
    while (n_acc < 8 && budget < 50) begin cyc(1'b1, 1'b0, 1'b0, 1'b0); budget++; end
    check_eq("t1_timeout", 64'(n_acc), 64'd8);
    drain(3);
    check_eq("t1_beat", {60'd0, beat_cnt}, 64'd8);

    // WR_FULL held while streaming: exactly two words absorbed
    start = n_acc;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t2_accepted", 64'(n_acc - start), 64'd2);
    check_eq("t2_buf_cnt", {62'd0, buf_cnt}, 64'd2);
    check_eq("t2_rdy", {63'd0, in_rdy}, 64'd0);
    drain(3);
    check_eq("t2_beat", {60'd0, beat_cnt}, 64'd10);

    // Refill to two, then flush with a word presented
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t4_pre_cnt", {62'd0, buf_cnt}, 64'd2);
    beat_save = m_beat;
    start = n_acc;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t4_cnt", {62'd0, buf_cnt}, 64'd0);
    check_eq("t4_rdy", {63'd0, in_rdy}, 64'd1);
    check_eq("t4_no_accept", 64'(n_acc - start), 64'd0);
    drain(2);
    check_eq("t4_beat", {60'd0, beat_cnt}, 64'(beat_save % 16));

    // Random valid and WR_FULL over 1000 words
    start = n_acc;
    budget = 0;
    while ((n_acc - start) < 1000 && budget < 20000) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
      budget++;
    end
    check_eq("t3_words", 64'(n_acc - start), 64'd1000);
    drain(3);

    // Reset with one word buffered: it must never be written
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t6_pre_cnt", {62'd0, buf_cnt}, 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_cnt", {62'd0, buf_cnt}, 64'd0);
    check_eq("t6_rdy_rst", {63'd0, in_rdy}, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_rdy_after", {63'd0, in_rdy}, 64'd1);
    drain(3);

    // 17 words after reset wraps the 4-bit beat counter to 1
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    start = n_acc;
    budget = 0;
    while ((n_acc - start) < 17 && budget < 100) begin cyc(1'b1, 1'b0, 1'b0, 1'b0); budget++; end
    drain(3);
    check_eq("t5_beat_wrap", {60'd0, beat_cnt}, 64'd1);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
